core_cluster: RTL and testbench
===============================

# core_cluster

Cluster of `NUM_CORES` processor cores sharing a single device bus. Each core issues device reads and writes through a private request port. The cluster arbitrates round-robin among them and drives one transaction at a time onto the device bus, tagged with the issuing core's ID. It sits directly under the chip top, which decodes device addresses (console output, hardware mutexes) and returns registered read data.

## Interface
- `NUM_CORES`, default 16: number of cores instantiated; legal range 2..16.
- `CORE_ID_W`, derived as `$clog2(NUM_CORES)` (4 at the default); width of `device_core_id`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `device_core_id` out `CORE_ID_W`: ID of the core owning the current bus transaction.
- `device_write_en` out 1: one-cycle write strobe.
- `device_read_en` out 1: one-cycle read strobe.
- `device_addr` out 10: device address.
- `device_data_out` out 16: write data.
- `device_data_in` in 16: read data, registered by the device one cycle after the strobe.

## Operation
- Instantiates `core` (existing block) `NUM_CORES` times, with `CORE_ID` = 0..NUM_CORES-1.
- Per-core port signals:
  - `io_request`, `io_write`, `io_addr[9:0]`, `io_wdata[15:0]`: from the core.
  - `io_ack`, `io_rdata[15:0]`: to the core.
- A core holds its request fields stable until it samples `io_ack`=1, then may drop or re-raise its request.
- Only one transaction is outstanding at a time.
- FSM states and transitions:
  - IDLE: if any `io_request` is set, grant the winner, latch its addr/data/write/ID into output registers, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: registered bus outputs are valid for exactly this cycle. `device_write_en`=`io_write` and `device_read_en`=!`io_write`. For a write, pulse `io_ack` to the granted core and go to IDLE. For a read, go to WAIT.
  - WAIT: pulse `io_ack` to the granted core with `io_rdata`=`device_data_in` (combinational pass-through), then go to IDLE.
- Arbitration is round-robin. Priority starts at the core after the last granted core; after reset it starts at core 0.
- The granted ID and its mux select are held from IDLE through the end of the transaction.
- Outside ISSUE: both strobes are 0, and `device_addr`, `device_data_out` and `device_core_id` are driven to 0.
- `io_rdata` reads 0 to all cores except the acked reader in WAIT.
- `io_ack` is high for exactly one cycle per transaction, and only to the granted core.

## Timing
- Request seen high at the edge ending IDLE → strobe in the following cycle (ISSUE).
- Write latency: request to ack is 1 cycle after the grant edge. Throughput is 1 write per 2 cycles.
- Read latency: ack in the cycle after the strobe. Throughput is 1 read per 3 cycles.
- `device_core_id` is valid in the same cycle as the strobe; the device uses it for mutex ownership.
- A core re-requesting immediately after its ack competes normally; round-robin prevents starvation. With all cores requesting, every core is served within `NUM_CORES` transactions.
- Asserting `reset` mid-transaction:
  - clears the FSM to IDLE, the outputs to 0 and the priority pointer to core 0;
  - drops any in-flight read with no ack.

## Structure
- Shared package `cluster_pkg` holds:
  - `DEV_ADDR_W`=10 and `DEV_DATA_W`=16;
  - device address constants `ADDR_OUTPUT`='h3ff, `ADDR_MUTEX0`='h3fe and `ADDR_MUTEX1`='h3fd;
  - the FSM state enum.
- One natural sub-module is `cluster_arbiter`: round-robin, one-hot/encoded grant, update enabled on the grant edge.
- Core request/response muxing stays in the cluster.

## Test plan
(Cores replaced by driver stubs.)
- Reset low for 3 cycles, then release → all device outputs 0 and no `io_ack`.
- Core 5 writes addr 'h3ff, data 'h1234 → ISSUE cycle shows write_en=1, addr='h3ff, data='h1234 and core_id=5; `io_ack`[5] pulses in the same cycle; next cycle all outputs are 0.
- Core 2 reads 'h3fe while the device model returns 'h0001 in the next cycle → read_en for one cycle, then `io_ack`[2] with `io_rdata`='h0001.
- All 16 cores request simultaneously after reset → grants in order 0,1,…,15; core 0 re-requesting is served again only after core 15.
- Cores 3 and 9 request continuously → grants alternate 3,9,3,9.
- Reset asserted during WAIT of a core 7 read → no ack to core 7; after release the first grant follows the core 0 priority order.

Source files
------------

// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - shared device bus widths, device addresses and cluster FSM state
package cluster_pkg;

    localparam int DEV_ADDR_W = 10;
    localparam int DEV_DATA_W = 16;

    // Device map decoded by the chip top
    localparam logic [DEV_ADDR_W-1:0] ADDR_OUTPUT = 10'h3ff;
    localparam logic [DEV_ADDR_W-1:0] ADDR_MUTEX0 = 10'h3fe;
    localparam logic [DEV_ADDR_W-1:0] ADDR_MUTEX1 = 10'h3fd;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } cluster_state_t;

endpackage

// File: rtl/cluster_arbiter.sv
// rtl/cluster_arbiter.sv - round-robin arbiter with one-hot and encoded grant
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   request        per-core request vector
//   update         advance the priority pointer past the current winner this edge
//   grant_valid    at least one request present
//   grant_onehot   winner as a one-hot vector
//   grant_id       winner as an index
module cluster_arbiter #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         update,
    output logic         grant_valid,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] grant_id
);

    // Index of the highest-priority core
    logic [W-1:0] ptr;

    always_comb begin
        int           idx;
        logic [W-1:0] idx_w;
        grant_valid  = 1'b0;
        grant_onehot = '0;
        grant_id     = '0;
        idx          = 0;
        idx_w        = '0;
        // Walk from ptr upward with wrap; the first requester found wins
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = W'(idx);
            if (!grant_valid && request[idx_w]) begin
                grant_valid         = 1'b1;
                grant_onehot[idx_w] = 1'b1;
                grant_id            = idx_w;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (update && grant_valid) begin
            ptr <= (grant_id == W'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/core.sv
// rtl/core.sv - request-port stand-in for the processor core, loaded with commands from outside
// Ports:
//   clk, reset                  clock, asynchronous active-low reset (unused by this stand-in)
//   io_request                  high while commands remain un-acked
//   io_write, io_addr, io_wdata current command fields, held stable until ack
//   io_ack, io_rdata            response from the cluster
// The command fields and stim_seq are loaded hierarchically; every ack retires one
// command. Pending commands survive a reset, like a core that never saw its ack.
module core
    import cluster_pkg::*;
#(
    parameter int CORE_ID = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  io_request,
    output logic                  io_write,
    output logic [DEV_ADDR_W-1:0] io_addr,
    output logic [DEV_DATA_W-1:0] io_wdata,
    input  logic                  io_ack,
    input  logic [DEV_DATA_W-1:0] io_rdata
);

    logic [7:0]            stim_seq   = 8'd0;
    logic                  stim_write = 1'b0;
    logic [DEV_ADDR_W-1:0] stim_addr  = '0;
    logic [DEV_DATA_W-1:0] stim_wdata = '0;
    logic [7:0]            done_seq   = 8'd0;

    logic [DEV_DATA_W:0]   resp_unused;
    assign resp_unused = {reset, io_rdata};

    always_ff @(posedge clk) begin
        if (io_ack) begin
            done_seq <= done_seq + 8'd1;
        end
    end

    assign io_request = (stim_seq != done_seq);
    assign io_write   = stim_write;
    assign io_addr    = stim_addr;
    assign io_wdata   = stim_wdata;

endmodule

// File: rtl/core_cluster.sv
// rtl/core_cluster.sv - NUM_CORES cores sharing one device bus through a round-robin arbiter
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   device_core_id    owner of the current transaction (valid with the strobe)
//   device_write_en   one-cycle write strobe
//   device_read_en    one-cycle read strobe
//   device_addr       device address (zero outside the strobe cycle)
//   device_data_out   write data (zero outside the strobe cycle)
//   device_data_in    read data, registered by the device one cycle after the strobe
module core_cluster
    import cluster_pkg::*;
#(
    parameter int NUM_CORES = 16,
    localparam int CORE_ID_W = $clog2(NUM_CORES)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [CORE_ID_W-1:0]  device_core_id,
    output logic                  device_write_en,
    output logic                  device_read_en,
    output logic [DEV_ADDR_W-1:0] device_addr,
    output logic [DEV_DATA_W-1:0] device_data_out,
    input  logic [DEV_DATA_W-1:0] device_data_in
);

    logic [NUM_CORES-1:0]  io_request;
    logic [NUM_CORES-1:0]  io_write;
    logic [DEV_ADDR_W-1:0] io_addr  [NUM_CORES];
    logic [DEV_DATA_W-1:0] io_wdata [NUM_CORES];
    logic [NUM_CORES-1:0]  io_ack;
    logic [DEV_DATA_W-1:0] io_rdata [NUM_CORES];

    cluster_state_t        state;
    logic [CORE_ID_W-1:0]  sel_id;
    logic [NUM_CORES-1:0]  sel_onehot;
    logic                  ack_q;

    logic                  grant_valid;
    logic [NUM_CORES-1:0]  grant_onehot;
    logic [CORE_ID_W-1:0]  grant_id;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core #(
            .CORE_ID (i)
        ) u_core (
            .clk        (clk),
            .reset      (reset),
            .io_request (io_request[i]),
            .io_write   (io_write[i]),
            .io_addr    (io_addr[i]),
            .io_wdata   (io_wdata[i]),
            .io_ack     (io_ack[i]),
            .io_rdata   (io_rdata[i])
        );

        // Only the acked reader sees the device data; everyone else reads zero
        assign io_rdata[i] = (state == ST_WAIT && ack_q && sel_onehot[i]) ? device_data_in : '0;
    end

    assign io_ack = ack_q ? sel_onehot : '0;

    // The pointer only moves on the edge that leaves IDLE with a winner
    cluster_arbiter #(
        .N (NUM_CORES),
        .W (CORE_ID_W)
    ) u_arbiter (
        .clk          (clk),
        .reset        (reset),
        .request      (io_request),
        .update       (state == ST_IDLE),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            sel_id          <= '0;
            sel_onehot      <= '0;
            ack_q           <= 1'b0;
            device_core_id  <= '0;
            device_write_en <= 1'b0;
            device_read_en  <= 1'b0;
            device_addr     <= '0;
            device_data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        sel_id          <= grant_id;
                        sel_onehot      <= grant_onehot;
                        device_core_id  <= grant_id;
                        device_write_en <= io_write[grant_id];
                        device_read_en  <= !io_write[grant_id];
                        device_addr     <= io_addr[grant_id];
                        device_data_out <= io_wdata[grant_id];
                        // Writes are acked alongside the strobe
                        ack_q           <= io_write[grant_id];
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    device_core_id  <= '0;
                    device_write_en <= 1'b0;
                    device_read_en  <= 1'b0;
                    device_addr     <= '0;
                    device_data_out <= '0;
                    if (device_write_en) begin
                        ack_q <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        // Reads are acked once the device data has been registered
                        ack_q <= 1'b1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [CORE_ID_W-1:0] sel_id_unused;
    assign sel_id_unused = sel_id;

endmodule

// File: tb/tb_core_cluster.sv
// tb/tb_core_cluster.sv - scoreboard bench for core_cluster with hierarchically loaded core stand-ins
module tb_core_cluster;
    import cluster_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  device_core_id;
    logic        device_write_en;
    logic        device_read_en;
    logic [9:0]  device_addr;
    logic [15:0] device_data_out;
    logic [15:0] device_data_in = 16'h0;

    always #5 clk = ~clk;

    core_cluster #(.NUM_CORES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .device_core_id  (device_core_id),
        .device_write_en (device_write_en),
        .device_read_en  (device_read_en),
        .device_addr     (device_addr),
        .device_data_out (device_data_out),
        .device_data_in  (device_data_in)
    );

    typedef struct {
        int          core;
        bit          wr;
        logic [9:0]  addr;
        logic [15:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  tb_seq  [N] = '{default: 8'd0};
    logic        tb_wr   [N] = '{default: 1'b0};
    logic [9:0]  tb_addr [N] = '{default: 10'd0};
    logic [15:0] tb_data [N] = '{default: 16'd0};

    bit          rd_pending = 0;
    int          rd_core = 0;
    logic [15:0] rd_exp = 16'h0;
    txn_t        mon_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] dev_val(input logic [9:0] a);
        if (a == ADDR_MUTEX0) return 16'h0001;
        return {6'h2a, a};
    endfunction

    // Load each stand-in's command registers away from the active edge
    for (genvar g = 0; g < N; g++) begin : g_stim
        always @(negedge clk) begin
            dut.g_core[g].u_core.stim_write = tb_wr[g];
            dut.g_core[g].u_core.stim_addr  = tb_addr[g];
            dut.g_core[g].u_core.stim_wdata = tb_data[g];
            dut.g_core[g].u_core.stim_seq   = tb_seq[g];
        end
    end

    // Device registers read data one cycle after the read strobe
    always @(posedge clk) begin
        if (device_read_en) device_data_in <= dev_val(device_addr);
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_strobe", {device_write_en, device_read_en}, 0);
            check("rst_ack", dut.io_ack, 0);
            rd_pending = 0;
        end else if (device_write_en || device_read_en) begin
            if (exp_q.size() == 0) begin
                check("unexp_strobe", {device_write_en, device_read_en}, 0);
            end else begin
                mon_t = exp_q.pop_front();
                check("core_id", device_core_id, mon_t.core);
                check("write_en", device_write_en, mon_t.wr);
                check("read_en", device_read_en, !mon_t.wr);
                check("addr", device_addr, mon_t.addr);
                check("data_out", device_data_out, mon_t.data);
                if (mon_t.wr) begin
                    check("wr_ack", dut.io_ack, 32'd1 << mon_t.core);
                end else begin
                    check("rd_early_ack", dut.io_ack, 0);
                    rd_pending = 1;
                    rd_core    = mon_t.core;
                    rd_exp     = dev_val(mon_t.addr);
                end
            end
        end else if (rd_pending) begin
            check("rd_ack", dut.io_ack, 32'd1 << rd_core);
            check("rd_data", dut.io_rdata[rd_core], rd_exp);
            check("rd_other", dut.io_rdata[(rd_core + 1) % N], 0);
            rd_pending = 0;
        end else begin
            check("idle_ack", dut.io_ack, 0);
            check("idle_bus", {device_addr, device_data_out, device_core_id}, 0);
        end
    end

    task automatic cmd(input int k, input bit wr, input logic [9:0] a, input logic [15:0] d, input int n);
        tb_wr[k]   = wr;
        tb_addr[k] = a;
        tb_data[k] = d;
        tb_seq[k]  = tb_seq[k] + 8'(n);
    endtask

    task automatic expect_txn(input int k);
        txn_t t;
        t.core = k;
        t.wr   = tb_wr[k];
        t.addr = tb_addr[k];
        t.data = tb_data[k];
        exp_q.push_back(t);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_pending) && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_strobes", {device_write_en, device_read_en}, 0);
        check("post_rst_bus", {device_addr, device_data_out, device_core_id}, 0);
        check("post_rst_ack", dut.io_ack, 0);
        @(posedge clk);
        #1;

        // Single write from core 5
        cmd(5, 1'b1, ADDR_OUTPUT, 16'h1234, 1);
        expect_txn(5);
        drain("drain_w5");

        // Single read from core 2 of the mutex
        @(posedge clk);
        #1;
        cmd(2, 1'b0, ADDR_MUTEX0, 16'h0000, 1);
        expect_txn(2);
        drain("drain_r2");

        // All cores at once after reset; core 0 asks twice and waits behind core 15
        pulse_reset(2);
        for (int k = 0; k < N; k++) begin
            cmd(k, 1'b1, 10'h100 + 10'(k), 16'ha000 + 16'(k), (k == 0) ? 2 : 1);
            expect_txn(k);
        end
        expect_txn(0);
        drain("drain_all");

        // Two continuous requesters alternate
        @(posedge clk);
        #1;
        cmd(3, 1'b0, ADDR_OUTPUT, 16'h0333, 2);
        cmd(9, 1'b1, 10'h055, 16'h9999, 2);
        expect_txn(3);
        expect_txn(9);
        expect_txn(3);
        expect_txn(9);
        drain("drain_alt");

        // Reset during the WAIT of a core 7 read
        @(posedge clk);
        #1;
        cmd(7, 1'b0, ADDR_MUTEX1, 16'h0777, 1);
        expect_txn(7);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!device_read_en && n < 50);
        check("rd7_strobe", device_read_en, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        // Core 7 never saw an ack, so it still requests; the new order starts at core 0
        cmd(2, 1'b1, 10'h022, 16'h2222, 1);
        cmd(12, 1'b1, 10'h0cc, 16'hcccc, 1);
        check("rd7_dropped", exp_q.size(), 0);
        expect_txn(2);
        expect_txn(7);
        expect_txn(12);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        drain("drain_post_rst");

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
